// File: rtl/ir_sirc_transmitter_if.sv
// SIRC transmitter control/status bundle.
// master: control side (start, command, address); slave: transmitter.
interface ir_sirc_transmitter_if;
    logic       start;
    logic [6:0] command;
    logic [4:0] address;
    logic       busy;
    logic       done;
    logic       envelope;
    logic       ir_out;

    modport master (
        output start, command, address,
        input  busy, done, envelope, ir_out
    );

    modport slave (
        input  start, command, address,
        output busy, done, envelope, ir_out
    );
endinterface

// File: rtl/ir_sirc_transmitter.sv
// Sony SIRC IR transmitter: 12-bit frame, 600us units, 40kHz carrier.
// Ports: clk, reset_n (async low), bus (slave: start/command/address in,
// busy/done/envelope/ir_out out).
module ir_sirc_transmitter #(
    parameter int UNIT_COUNT   = 16200,
    parameter int CARRIER_HALF = 338,
    parameter int GAP_UNITS    = 20
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ir_sirc_transmitter_if.slave bus
);
    localparam int UW   = (UNIT_COUNT > 1) ? $clog2(UNIT_COUNT) : 1;
    localparam int CW   = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam int MAXU = (GAP_UNITS > 4) ? GAP_UNITS : 4;
    localparam int NW   = $clog2(MAXU);

    typedef enum logic [2:0] {
        IDLE, START, SPACE, BIT_MARK, GAP
    } state_t;

    state_t          state_q, state_d;
    logic [UW-1:0]   unit_q, unit_d;
    logic [NW-1:0]   units_q, units_d;
    logic [3:0]      bit_q, bit_d;
    logic [11:0]     shift_q, shift_d;
    logic [CW-1:0]   carr_cnt_q, carr_cnt_d;
    logic            carr_q, carr_d;
    logic            env_q, env_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            unit_tick;
    logic            last_unit;
    logic [NW-1:0]   len_m1;
    logic            enter;
    logic            mark;

    always_comb begin
        state_d    = state_q;
        unit_d     = unit_q;
        units_d    = units_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        carr_cnt_d = carr_cnt_q;
        carr_d     = carr_q;
        env_d      = env_q;
        done_d     = 1'b0;
        enter      = 1'b0;
        mark       = 1'b0;

        unit_tick = (unit_q == UW'(UNIT_COUNT - 1));

        unique case (state_q)
            START:    len_m1 = NW'(3);
            BIT_MARK: len_m1 = shift_q[0] ? NW'(1) : NW'(0);
            GAP:      len_m1 = NW'(GAP_UNITS - 1);
            default:  len_m1 = '0;
        endcase

        last_unit = unit_tick && (units_q == len_m1);

        if (state_q != IDLE) begin
            unit_d = unit_tick ? '0 : unit_q + UW'(1);
            if (unit_tick) begin
                units_d = units_q + NW'(1);
            end
        end

        // Carrier only runs during marks; it is re-phased on mark entry.
        if (env_q) begin
            if (carr_cnt_q == CW'(CARRIER_HALF - 1)) begin
                carr_cnt_d = '0;
                carr_d     = ~carr_q;
            end else begin
                carr_cnt_d = carr_cnt_q + CW'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                // done_q blocks a held start on the completion cycle.
                if (bus.start && !done_q) begin
                    shift_d = {bus.address, bus.command};
                    bit_d   = '0;
                    state_d = START;
                    enter   = 1'b1;
                    mark    = 1'b1;
                end
            end
            START: begin
                if (last_unit) begin
                    state_d = SPACE;
                    enter   = 1'b1;
                end
            end
            SPACE: begin
                if (last_unit) begin
                    enter = 1'b1;
                    if (bit_q == 4'd12) begin
                        state_d = GAP;
                    end else begin
                        state_d = BIT_MARK;
                        mark    = 1'b1;
                    end
                end
            end
            BIT_MARK: begin
                if (last_unit) begin
                    state_d = SPACE;
                    enter   = 1'b1;
                    shift_d = {1'b0, shift_q[11:1]};
                    bit_d   = bit_q + 4'd1;
                end
            end
            GAP: begin
                if (last_unit) begin
                    state_d = IDLE;
                    enter   = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                enter   = 1'b1;
            end
        endcase

        if (enter) begin
            unit_d     = '0;
            units_d    = '0;
            env_d      = mark;
            carr_cnt_d = '0;
            carr_d     = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            unit_q     <= '0;
            units_q    <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            carr_cnt_q <= '0;
            carr_q     <= 1'b0;
            env_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            unit_q     <= unit_d;
            units_q    <= units_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            carr_cnt_q <= carr_cnt_d;
            carr_q     <= carr_d;
            env_q      <= env_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.envelope = env_q;
    assign bus.ir_out   = env_q & carr_q;
endmodule

// File: doc/ir_sirc_transmitter.md
Name: ir_sirc_transmitter

Overview:
- Sony SIRC-format IR remote transmitter; the transmit-side counterpart of the team's 600us-unit IR receive path.
- Serialises a 12-bit frame (7-bit command, 5-bit address, LSB first) into 600us-unit pulse-width-coded marks and spaces.
- Drives an IR LED with a 40kHz carrier during marks and with 0 during spaces.
- Sits between control logic (one-shot start request) and the LED output pin.

Parameters:
UNIT_COUNT, 16200, clk cycles per 600us unit (27MHz clock; 15000 for 25MHz)
CARRIER_HALF, 338, clk cycles per carrier half-period (~40kHz at 27MHz; 313 for 25MHz)
GAP_UNITS, 20, low units appended after the last bit before the block returns idle

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
start  input  1  request to send a frame; sampled only in IDLE
command  input  7  command field; latched when start is accepted
address  input  5  address field; latched when start is accepted
busy  output  1  high while a frame (including gap) is in progress
done  output  1  one-cycle pulse when frame plus gap completes
envelope  output  1  unmodulated mark/space envelope (1 = mark)
ir_out  output  1  envelope AND carrier; drives the LED

Behaviour:
- Reset: reset_n low immediately forces IDLE. busy=0, done=0, envelope=0, ir_out=0. All counters and the shift register clear. This applies mid-frame; no partial frame resumes after reset.
- Accept: a cycle with state==IDLE and start==1 latches {address,command} into a 12-bit shift register. On the next cycle: busy=1, state=START, envelope=1, unit counter=0.
- start is ignored while busy, including on the done cycle. start held high re-triggers on the first IDLE cycle after done.
- Unit timer counts 0..UNIT_COUNT-1. unit_tick is asserted when the count equals UNIT_COUNT-1; the counter then wraps to 0. The timer restarts at 0 on every state entry.
- States and transitions:
  - IDLE.
  - START: mark of 4 units, then SPACE.
  - SPACE: 1 unit low, then BIT_MARK, or GAP if 12 bits have been sent.
  - BIT_MARK: mark of 2 units if the current bit is 1, or 1 unit if 0; then SPACE. The shift register shifts right and the bit counter increments on leaving BIT_MARK.
  - GAP: GAP_UNITS units low, then IDLE.
- Bit order: command[0]..command[6], then address[0]..address[4].
- envelope=1 exactly in START and BIT_MARK; 0 otherwise.
- Carrier: the counter and phase reset on every mark entry, so carrier=1 for the first CARRIER_HALF cycles of each mark, then toggles every CARRIER_HALF cycles. ir_out=0 whenever envelope=0.
- Frame length in units = 4 + 1 + sum over the 12 bits of (bit ? 3 : 2) + GAP_UNITS. busy is high for exactly (frame units × UNIT_COUNT) cycles.
- done=1 on the first cycle busy=0 after a frame, for exactly 1 cycle.
- Counter widths: $clog2 of the corresponding parameter; no overflow is allowed.

Test Plan:
- Common sim parameters: UNIT_COUNT=10, CARRIER_HALF=2, GAP_UNITS=3.
1. Reset: reset_n=0 asynchronously mid-START -> ir_out, envelope, busy go 0 without waiting for a clk edge. After release, state is IDLE and done stays 0.
2. Basic frame: start pulse with command=0x15, address=0x01 -> envelope high for 40 cycles, then marks of 20,10,20,10,20,10,10,20,10,10,10,10 cycles, each followed by a 10-cycle space. Gap is 30 cycles. busy lasts 360 cycles and done pulses once.
3. Carrier: during any mark -> ir_out pattern is 1,1,0,0 repeating, starting high at mark entry. ir_out=0 throughout every space and the gap.
4. Busy rejection: start pulsed during bit 5, and data inputs changed mid-frame -> transmitted bits are unchanged, frame length stays 360 cycles, and no second frame follows.
5. Back-to-back: start held high continuously -> a second frame begins the cycle after done, with a 30-cycle gap between frames. Test all-ones (0x7F/0x1F -> busy 440 cycles) and all-zeros (busy 320 cycles).
